// File: rtl/ahb_slave1_sram.sv
// ahb_slave1_sram: AHB-Lite SRAM slave with byte lanes, programmable wait states and a two-cycle ERROR response
module ahb_slave1_sram #(
   parameter int DEPTH       = 256,
   parameter int REGION_BITS = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSELS1,
   input  logic [31:0] HADDRS1,
   input  logic [1:0]  HTRANSS1,
   input  logic        HWRITES1,
   input  logic [2:0]  HSIZES1,
   input  logic [31:0] HWDATAS1,
   input  logic        HREADYS1,
   output logic [31:0] HRDATAS1,
   output logic        HREADYOUTS1,
   output logic        HRESPS1
);
   localparam int IW = REGION_BITS - 2;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
   state_t         state, state_nx;
   logic [3:0]     cnt, cnt_nx;
   logic [31:0]    mem [DEPTH];
   logic [1:0]     a;
   logic [IW-1:0]  idx;
   logic [AW-1:0]  ph_idx;
   logic [3:0]     lane, ph_mask;
   logic [31:0]    rd_word;
   logic           acc, legal, wr_now, ph_valid, ph_write;
   logic           unused_bits;
   assign unused_bits = ^{HADDRS1[31:REGION_BITS], HTRANSS1[0]};
   assign a      = HADDRS1[1:0];
   assign idx    = HADDRS1[REGION_BITS-1:2];
   assign acc    = HSELS1 & HTRANSS1[1] & HREADYS1 & (state == IDLE);
   assign legal  = ((HSIZES1 == 3'd0) | ((HSIZES1 == 3'd1) & ~a[0]) | ((HSIZES1 == 3'd2) & (a == 2'b00)))
                   & (32'(idx) < 32'(DEPTH));
   assign lane   = (HSIZES1 == 3'd0) ? (4'b0001 << a) : (HSIZES1 == 3'd1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wr_now = ph_valid & ph_write & (state == IDLE);
   // read word seen at accept, with lanes of a same-cycle completing write bypassed in
   always_comb begin
      rd_word = mem[idx[AW-1:0]];
      for (int b = 0; b < 4; b++)
         rd_word[8*b +: 8] = (wr_now & ph_mask[b] & (ph_idx == idx[AW-1:0])) ? HWDATAS1[8*b +: 8] : rd_word[8*b +: 8];
   end
   // byte-lane write on the completing data-phase edge; reset drops a pending write
   always_ff @(posedge HCLK)
      if (wr_now & ~HRESET)
         for (int b = 0; b < 4; b++)
            if (ph_mask[b]) mem[ph_idx][8*b +: 8] <= HWDATAS1[8*b +: 8];
   // data-phase bookkeeping and registered read data
   always_ff @(posedge HCLK)
      if (HRESET) begin
         ph_valid <= 1'b0;
         ph_write <= 1'b0;
         ph_idx   <= '0;
         ph_mask  <= '0;
         HRDATAS1 <= '0;
      end else begin
         if (state == IDLE) ph_valid <= acc & legal;
         if (acc & legal) begin
            ph_write <= HWRITES1;
            ph_idx   <= idx[AW-1:0];
            ph_mask  <= lane;
            if (!HWRITES1) HRDATAS1 <= rd_word;
         end
      end
   // state and wait counter registers
   always_ff @(posedge HCLK)
      if (HRESET) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   // next state, wait countdown and response outputs
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      HREADYOUTS1 = 1'b1;
      HRESPS1     = 1'b0;
      case (state)
         IDLE: if (acc) begin
            if (!legal) state_nx = ERR1;
            else if (WAIT_STATES > 0) begin
               state_nx = WAIT;
               cnt_nx   = 4'(WAIT_STATES);
            end
         end
         WAIT: begin
            HREADYOUTS1 = 1'b0;
            cnt_nx      = cnt - 4'd1;
            state_nx    = (cnt == 4'd1) ? IDLE : WAIT;
         end
         ERR1: begin
            HREADYOUTS1 = 1'b0;
            HRESPS1     = 1'b1;
            state_nx    = ERR2;
         end
         ERR2: begin
            HRESPS1  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule
